// File: rtl/debounced_synchronizer.sv
// Multi-channel synchronizer with per-channel debounce filter and edge strobes.
// Optional rejected-glitch counter enabled by DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN.
module debounced_synchronizer #(
  parameter int unsigned       WIDTH            = 1,
  parameter int unsigned       SYNC_DEPTH       = 2,
  parameter int unsigned       DEBOUNCE_CYCLES  = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE      = '0,
  parameter int unsigned       GLITCH_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in,
  output logic [WIDTH-1:0]            out,
  output logic [WIDTH-1:0]            rising_edge,
  output logic [WIDTH-1:0]            falling_edge,
  output logic                        any_edge
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
  ,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_count,
  input  logic                        glitch_clear
`endif
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} ch_state_e;

  logic [WIDTH-1:0] chain [SYNC_DEPTH];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] out_prev;
  logic [WIDTH-1:0] out_next;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  ch_state_e        state    [WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_DEPTH; s++) chain[s] <= RESET_VALUE;
    end else begin
      chain[0] <= in;
      for (int unsigned s = 1; s < SYNC_DEPTH; s++) chain[s] <= chain[s-1];
    end
  end

  assign sync = chain[SYNC_DEPTH-1];

  // The per-channel state is implied by the counter: nonzero means a change is pending.
  always_comb begin
    out_next = out;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state[i]    = (cnt[i] == '0) ? STABLE : PENDING;
      cnt_next[i] = '0;
      unique case (state[i])
        STABLE: begin
          if (sync[i] != out[i]) begin
            if (CNT_LAST == '0) out_next[i] = sync[i];
            else                cnt_next[i] = CW'(1);
          end
        end
        PENDING: begin
          if (sync[i] != out[i]) begin
            if (cnt[i] == CNT_LAST) out_next[i] = sync[i];
            else                    cnt_next[i] = cnt[i] + CW'(1);
          end
        end
        default: cnt_next[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= RESET_VALUE;
      out_prev <= RESET_VALUE;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      out      <= out_next;
      out_prev <= out;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign rising_edge  = out & ~out_prev;
  assign falling_edge = ~out & out_prev;
  assign any_edge     = |(rising_edge | falling_edge);

`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
  localparam int unsigned NW = $clog2(WIDTH + 1);
  localparam int unsigned SW = GLITCH_CNT_WIDTH + NW;

  logic [WIDTH-1:0] revert;
  logic [NW-1:0]    n_revert;
  logic [SW-1:0]    glitch_sum;

  // Widened sum lets saturation be detected from the carry bits.
  always_comb begin
    n_revert = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      revert[i] = (state[i] == PENDING) && (sync[i] == out[i]);
      n_revert  = n_revert + NW'(revert[i]);
    end
    glitch_sum = SW'(glitch_count) + SW'(n_revert);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         glitch_count <= '0;
    else if (glitch_clear)                           glitch_count <= '0;
    else if (glitch_sum[SW-1:GLITCH_CNT_WIDTH] != '0) glitch_count <= '1;
    else                                             glitch_count <= glitch_sum[GLITCH_CNT_WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_debounced_synchronizer.sv
// Randomized self-checking bench for debounced_synchronizer (two configurations).
// Reference model: a channel commits once its last DEBOUNCE_CYCLES synchronized samples all differ from out.
module tb_debounced_synchronizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       gclr;
  logic [3:0] a_in, a_out, a_rise, a_fall;
  logic       a_any;
  logic [2:0] b_in, b_out, b_rise, b_fall;
  logic       b_any;
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
  logic [1:0]  a_gc;
  logic [15:0] b_gc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debounced_synchronizer #(
    .WIDTH(4), .SYNC_DEPTH(2), .DEBOUNCE_CYCLES(4),
    .RESET_VALUE(4'b1111), .GLITCH_CNT_WIDTH(2)
  ) u_a (
    .clk(clk), .rst(rst), .in(a_in), .out(a_out),
    .rising_edge(a_rise), .falling_edge(a_fall), .any_edge(a_any)
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
    , .glitch_count(a_gc), .glitch_clear(gclr)
`endif
  );

  debounced_synchronizer #(
    .WIDTH(3), .SYNC_DEPTH(3), .DEBOUNCE_CYCLES(1),
    .RESET_VALUE(3'b000), .GLITCH_CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .rst(rst), .in(b_in), .out(b_out),
    .rising_edge(b_rise), .falling_edge(b_fall), .any_edge(b_any)
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
    , .glitch_count(b_gc), .glitch_clear(gclr)
`endif
  );

  // Reference model state, index 0 = u_a, 1 = u_b.
  logic [3:0] m_dl   [2][4];
  logic [3:0] m_hist [2][8];
  int         m_hn   [2];
  logic [3:0] m_out  [2];
  logic [3:0] m_prev [2];
  int         m_gc   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rv(input int k);
    return (k == 0) ? 4'b1111 : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) m_dl[k][j] = rv(k);
      m_hn[k]   = 0;
      m_out[k]  = rv(k);
      m_prev[k] = rv(k);
      m_gc[k]   = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] din, input logic clr);
    int sd, d, w, cap, ng;
    logic [3:0] s, cur, nxt;
    bit all_diff;
    sd  = (k == 0) ? 2 : 3;
    d   = (k == 0) ? 4 : 1;
    w   = (k == 0) ? 4 : 3;
    cap = (k == 0) ? 3 : 65535;
    s = m_dl[k][sd-1];
    for (int j = sd - 1; j > 0; j--) m_dl[k][j] = m_dl[k][j-1];
    m_dl[k][0] = din;
    for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = s;
    if (m_hn[k] < 8) m_hn[k]++;
    cur = m_out[k];
    nxt = cur;
    ng  = 0;
    for (int b = 0; b < w; b++) begin
      if (m_hn[k] >= 2 && m_hist[k][0][b] == cur[b] && m_hist[k][1][b] != cur[b]) ng++;
      if (m_hn[k] >= d) begin
        all_diff = 1'b1;
        for (int j = 0; j < d; j++) if (m_hist[k][j][b] == cur[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~cur[b];
      end
    end
    m_prev[k] = cur;
    m_out[k]  = nxt;
    if (clr) m_gc[k] = 0;
    else     m_gc[k] = (m_gc[k] + ng > cap) ? cap : m_gc[k] + ng;
  endtask

  task automatic compare_all();
    check("a_out",  32'(a_out),  32'(m_out[0]));
    check("a_rise", 32'(a_rise), 32'(m_out[0] & ~m_prev[0]));
    check("a_fall", 32'(a_fall), 32'(~m_out[0] & m_prev[0]));
    check("a_any",  32'(a_any),  32'(|(m_out[0] ^ m_prev[0])));
    check("b_out",  32'(b_out),  32'(m_out[1][2:0]));
    check("b_rise", 32'(b_rise), 32'(m_out[1][2:0] & ~m_prev[1][2:0]));
    check("b_fall", 32'(b_fall), 32'(~m_out[1][2:0] & m_prev[1][2:0]));
    check("b_any",  32'(b_any),  32'(|(m_out[1][2:0] ^ m_prev[1][2:0])));
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
    check("a_gc", 32'(a_gc), 32'(m_gc[0]));
    check("b_gc", 32'(b_gc), 32'(m_gc[1]));
`endif
  endtask

  // One clock: advance model with the inputs seen at this edge, then compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_step(0, a_in, gclr);
      model_step(1, {1'b0, b_in}, gclr);
    end
    #1;
    compare_all();
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_a_out", 32'(a_out), 32'hF);
    check("rst_async_a_any", 32'(a_any), 32'h0);
  endtask

  int fall_hits;

  initial begin
    rst  = 1'b1;
    gclr = 1'b0;
    a_in = 4'b1111;
    b_in = 3'b000;
    model_reset();
    #2;
    compare_all();
    tick();
    tick();
    rst = 1'b0;
    check("reset_a_out", 32'(a_out), 32'hF);

    for (int c = 0; c < 8; c++) tick();
    check("a_quiet_any", 32'(a_any), 32'h0);

    // Single falling channel: exactly one falling strobe on bit 2.
    a_in = 4'b1011;
    fall_hits = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (a_fall == 4'b0100) fall_hits++;
    end
    check("a_fall_once", 32'(fall_hits), 32'd1);
    check("a_out_1011", 32'(a_out), 32'hB);

    // Three-cycle pulse is shorter than the filter and must be rejected.
    a_in = 4'b1010;
    for (int c = 0; c < 3; c++) tick();
    a_in = 4'b1011;
    for (int c = 0; c < 10; c++) tick();
    check("a_glitch_out", 32'(a_out), 32'hB);
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
    check("a_glitch_cnt1", 32'(a_gc), 32'd1);
`endif

    // Instance b (no filter): step to 101.
    b_in = 3'b101;
    for (int c = 0; c < 6; c++) tick();
    check("b_step_out", 32'(b_out), 32'h5);

    // Reset while channels are pending (cnt=2) discards progress.
    a_in = 4'b0100;
    for (int c = 0; c < 4; c++) tick();
    assert_reset();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("a_post_rst_hold", 32'(a_out), 32'hF);
    tick();
    check("a_post_rst_commit", 32'(a_out), 32'h4);
    for (int c = 0; c < 4; c++) tick();

    // Five short glitches on bit 2 saturate the 2-bit counter.
    for (int g = 0; g < 5; g++) begin
      a_in = 4'b0000;
      tick();
      tick();
      a_in = 4'b0100;
      for (int c = 0; c < 8; c++) tick();
    end
    check("a_out_after_glitches", 32'(a_out), 32'h4);
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
    check("a_gc_saturated", 32'(a_gc), 32'd3);
`endif

    // Clear coinciding with a reversion wins.
    a_in = 4'b0000;
    tick();
    tick();
    a_in = 4'b0100;
    tick();
    tick();
    gclr = 1'b1;
    tick();
    gclr = 1'b0;
`ifdef DEBOUNCED_SYNCHRONIZER_GLITCH_COUNT_EN
    check("a_gc_clear_prio", 32'(a_gc), 32'd0);
`endif
    for (int c = 0; c < 6; c++) tick();

    // Random phase: sparse toggles, occasional clear and reset pulses.
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 4) == 0) a_in[b] = ~a_in[b];
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 2) == 0) b_in[b] = ~b_in[b];
      gclr = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 250) == 0) begin
        assert_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
